// File: rtl/rtc_sqw_tick.sv
// rtc_sqw_tick: turns the RTC 1 Hz square wave into a clean one-cycle tick on
// hwclk. The input is synchronised, glitch-filtered and period-checked. Loss of
// the RTC signal is detected and flagged.
// Optional feature macro: SQW_FALLBACK_EN. When it is defined, a FALLBACK state
// with an internal CLK_HZ divider keeps ticks flowing while the RTC is missing.
`timescale 1ns/1ps
module rtc_sqw_tick #(
  parameter int unsigned CLK_HZ         = 12000000,
  parameter int unsigned FILTER_CYCLES  = 16,
  parameter int unsigned MIN_PERIOD     = 6000000,
  parameter int unsigned TIMEOUT_CYCLES = 18000000,
  parameter int unsigned LOCK_EDGES     = 2
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic       sqw,
  output logic       tick,
  output logic       locked,
  output logic       fallback,
  output logic       sqw_lost,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned PW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned GW = $clog2(LOCK_EDGES + 1);

  localparam logic [PW-1:0] MIN_P     = PW'(MIN_PERIOD);
  localparam logic [PW-1:0] TMO_P     = PW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [GW-1:0] LOCK_G    = GW'(LOCK_EDGES);

  // Code 2'b11 is never assigned; the next-state default sends it to SEARCH.
  typedef enum logic [1:0] {
    S_SEARCH   = 2'b00,
    S_LOCKED   = 2'b01,
    S_FALLBACK = 2'b10
  } state_e;

`ifdef SQW_FALLBACK_EN
  localparam state_e LOSS_STATE = S_FALLBACK;
`else
  localparam state_e LOSS_STATE = S_SEARCH;
`endif

  state_e          state_q, state_d;
  logic            sync1_q, sqw_s_q;
  logic            filt_q, filt_d, filt_prev_q;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   per_q, per_d;
  logic [GW-1:0]   good_q, good_d, good_inc;
  logic            first_q, first_d;
  logic            tick_q, tick_d;
  logic            lost_q, lost_d;
  logic [7:0]      glitch_q, glitch_d;

  logic edge_ev, accept, early, timeout, lock_edge;

  // Filter: filt follows sqw_s only after FILTER_CYCLES consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sqw_s_q != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = sqw_s_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, filter and edge-detect registers.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sqw_s_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      sync1_q     <= sqw;
      sqw_s_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
    end
  end

  // An edge only counts once the period check passes; an edge coinciding with
  // the timeout suppresses the timeout.
  assign edge_ev   = filt_q & ~filt_prev_q;
  assign accept    = edge_ev & ((per_q >= MIN_P) | first_q);
  assign early     = edge_ev & ~accept;
  assign timeout   = (per_q == TMO_P) & ~edge_ev;
  assign good_inc  = good_q + 1'b1;
  assign lock_edge = accept & (good_inc >= LOCK_G);

`ifdef SQW_FALLBACK_EN
  localparam int unsigned   DW       = $clog2(CLK_HZ + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HZ - 1);

  logic [DW-1:0] div_q, div_d;
  logic [PW-1:0] since_q, since_d;
  logic          div_fire, fb_entry, since_ok;

  assign fb_entry = (state_q != S_FALLBACK) && (state_d == S_FALLBACK);
  assign div_fire = (state_q == S_FALLBACK) && (div_q == DIV_LAST);
  assign since_ok = (since_q == MIN_P);

  // Divider runs only while staying in FALLBACK; since_q measures cycles
  // since the last fallback tick, saturating at MIN_PERIOD.
  always_comb begin
    div_d   = '0;
    since_d = since_q;
    if ((state_q == S_FALLBACK) && (state_d == S_FALLBACK)) begin
      div_d = div_fire ? '0 : div_q + 1'b1;
    end
    if (fb_entry || div_fire) begin
      since_d = '0;
    end else if (!since_ok) begin
      since_d = since_q + 1'b1;
    end
  end

  // Divider registers.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      since_q <= '0;
    end else begin
      div_q   <= div_d;
      since_q <= since_d;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q <= S_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEARCH: begin
        if (lock_edge) begin
          state_d = S_LOCKED;
        end else if (timeout) begin
          state_d = LOSS_STATE;
        end
      end
      S_LOCKED: begin
        if (timeout) begin
          state_d = LOSS_STATE;
        end
      end
`ifdef SQW_FALLBACK_EN
      S_FALLBACK: begin
        if (lock_edge) begin
          state_d = S_LOCKED;
        end
      end
`endif
      default: state_d = S_SEARCH;
    endcase
  end

  // FSM outputs: tick request and state flags.
  always_comb begin
    tick_d = 1'b0;
    case (state_q)
      S_SEARCH: tick_d = lock_edge;
      S_LOCKED: tick_d = accept;
`ifdef SQW_FALLBACK_EN
      // A locking edge too close to a divider tick would double-count the second.
      S_FALLBACK: tick_d = div_fire | (lock_edge & since_ok);
`endif
      default: tick_d = 1'b0;
    endcase
`ifdef SQW_FALLBACK_EN
    if (fb_entry) begin
      tick_d = 1'b1;
    end
    fallback = (state_q == S_FALLBACK);
`else
    fallback = 1'b0;
`endif
    locked = (state_q == S_LOCKED);
  end

  // Period counter, lock progress, first-edge flag, loss flag, glitch count.
  always_comb begin
    per_d = per_q;
    if (accept || timeout || (state_d != state_q)) begin
      per_d = '0;
    end else if (per_q != TMO_P) begin
      per_d = per_q + 1'b1;
    end

    good_d = good_q;
    if (timeout || (state_d != state_q) || (state_d == S_LOCKED)) begin
      good_d = '0;
    end else if (accept) begin
      good_d = good_inc;
    end

    first_d = first_q;
    if (accept) begin
      first_d = 1'b0;
    end
    if ((state_d == S_SEARCH) && ((state_q != S_SEARCH) || timeout)) begin
      first_d = 1'b1;
    end

    lost_d = lost_q | timeout;

    glitch_d = glitch_q;
    if (early && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  // Datapath registers; reset puts the block in SEARCH awaiting its first edge.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      per_q    <= '0;
      good_q   <= '0;
      first_q  <= 1'b1;
      tick_q   <= 1'b0;
      lost_q   <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      per_q    <= per_d;
      good_q   <= good_d;
      first_q  <= first_d;
      tick_q   <= tick_d;
      lost_q   <= lost_d;
      glitch_q <= glitch_d;
    end
  end

  assign tick       = tick_q;
  assign sqw_lost   = lost_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_rtc_sqw_tick.sv
// Directed bench for rtc_sqw_tick with small parameters (CLK_HZ=100, filter 4,
// min period 50, timeout 150, lock after 2 edges). Time t counts falling
// edges after reset release; sqw changes just after a falling edge and a tick
// is sampled on falling edges.
`timescale 1ns/1ps
module tb_rtc_sqw_tick;

  logic       hwclk;
  logic       reset;
  logic       sqw;
  logic       tick;
  logic       locked;
  logic       fallback;
  logic       sqw_lost;
  logic [7:0] glitch_cnt;

  int t;
  int tick_cnt;
  int last_tick_t;
  int n_tests;
  int n_fail;

`ifdef SQW_FALLBACK_EN
  localparam int FB        = 1;
  localparam int CNT_800   = 7;
  localparam int LAST_800  = 768;
  localparam int CNT_907   = 8;
  localparam int LAST_907  = 868;
  localparam int CNT_1007  = 9;
`else
  localparam int FB        = 0;
  localparam int CNT_800   = 4;
  localparam int LAST_800  = 417;
  localparam int CNT_907   = 5;
  localparam int LAST_907  = 907;
  localparam int CNT_1007  = 6;
`endif

  rtc_sqw_tick #(
    .CLK_HZ        (100),
    .FILTER_CYCLES (4),
    .MIN_PERIOD    (50),
    .TIMEOUT_CYCLES(150),
    .LOCK_EDGES    (2)
  ) dut (
    .hwclk     (hwclk),
    .reset     (reset),
    .sqw       (sqw),
    .tick      (tick),
    .locked    (locked),
    .fallback  (fallback),
    .sqw_lost  (sqw_lost),
    .glitch_cnt(glitch_cnt)
  );

  // Clock and reset.
  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  // Drive sqw at lvl for n cycles, counting ticks seen on each falling edge.
  task automatic hold(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      sqw = lvl;
      @(negedge hwclk);
      t++;
      if (tick === 1'b1) begin
        tick_cnt++;
        last_tick_t = t;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"},     32'(tick),       32'd0);
    check({tag, "_locked"},   32'(locked),     32'd0);
    check({tag, "_fallback"}, 32'(fallback),   32'd0);
    check({tag, "_lost"},     32'(sqw_lost),   32'd0);
    check({tag, "_glitch"},   32'(glitch_cnt), 32'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    t           = 0;
    tick_cnt    = 0;
    last_tick_t = -1;
    reset       = 1'b1;
    sqw         = 1'b0;

    // Reset state.
    hold(1'b0, 3);
    check_all_zero("reset");
    reset       = 1'b0;
    t           = 0;
    tick_cnt    = 0;
    last_tick_t = -1;

    // Rises at t=10 and t=110: first edge silent, second locks and ticks at 117.
    hold(1'b0, 10);
    hold(1'b1, 50);
    hold(1'b0, 50);
    check("first_edge_no_tick", 32'(tick_cnt), 32'd0);
    check("first_edge_unlocked", 32'(locked), 32'd0);
    hold(1'b1, 6);
    check("pre_lock_tick", 32'(tick_cnt), 32'd0);
    hold(1'b1, 1);
    check("lock_tick_at_7", 32'(tick), 32'd1);
    check("locked_on_2nd", 32'(locked), 32'd1);
    hold(1'b1, 43);
    hold(1'b0, 50);
    check("cnt_after_lock", 32'(tick_cnt), 32'd1);
    check("last_after_lock", 32'(last_tick_t), 32'd117);

    // Rise at 210 ticks at 217; a 3-cycle pulse at 270 is filtered out.
    hold(1'b1, 50);
    hold(1'b0, 10);
    hold(1'b1, 3);
    hold(1'b0, 37);
    check("short_pulse_cnt", 32'(tick_cnt), 32'd2);
    check("short_pulse_last", 32'(last_tick_t), 32'd217);
    check("short_pulse_glitch", 32'(glitch_cnt), 32'd0);

    // Rise at 310 ticks at 317; clean pulse at 330 is early: counted, no tick.
    hold(1'b1, 10);
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 70);
    check("early_edge_cnt", 32'(tick_cnt), 32'd3);
    check("early_edge_last", 32'(last_tick_t), 32'd317);
    check("early_edge_glitch", 32'(glitch_cnt), 32'd1);
    check("early_edge_locked", 32'(locked), 32'd1);

    // Rise at 410 still measured from the 317 edge, so it ticks at 417.
    hold(1'b1, 50);
    hold(1'b0, 50);
    check("after_early_cnt", 32'(tick_cnt), 32'd4);
    check("after_early_last", 32'(last_tick_t), 32'd417);

    // sqw stays low: timeout 150 cycles after the edge accepted at 417.
    hold(1'b0, 57);
    check("pre_timeout_lost", 32'(sqw_lost), 32'd0);
    check("pre_timeout_locked", 32'(locked), 32'd1);
    hold(1'b0, 1);
    check("timeout_lost", 32'(sqw_lost), 32'd1);
    check("timeout_unlocked", 32'(locked), 32'd0);
    check("timeout_fallback", 32'(fallback), 32'(FB));
    check("timeout_tick", 32'(tick), 32'(FB));
    hold(1'b0, 232);
    check("loss_cnt", 32'(tick_cnt), 32'(CNT_800));
    check("loss_last", 32'(last_tick_t), 32'(LAST_800));

    // Restart sqw with rises at 800 and 900; lock on the 900 edge.
    hold(1'b1, 50);
    hold(1'b0, 50);
    hold(1'b1, 6);
    check("relock_pending", 32'(locked), 32'd0);
    check("relock_pending_fb", 32'(fallback), 32'(FB));
    hold(1'b1, 1);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_fallback", 32'(fallback), 32'd0);
    check("relock_cnt", 32'(tick_cnt), 32'(CNT_907));
    check("relock_last", 32'(last_tick_t), 32'(LAST_907));
    check("relock_lost_sticky", 32'(sqw_lost), 32'd1);
    hold(1'b1, 43);
    hold(1'b0, 50);

    // Rise at 1000 ticks at 1007; reset lands while that tick is high.
    hold(1'b1, 7);
    check("regular_tick", 32'(tick), 32'd1);
    check("regular_cnt", 32'(tick_cnt), 32'(CNT_1007));
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    hold(1'b1, 3);
    reset = 1'b0;

    // After release the first edge is silent.
    hold(1'b1, 40);
    hold(1'b0, 50);
    check("post_reset_cnt", 32'(tick_cnt), 32'(CNT_1007));
    check("post_reset_locked", 32'(locked), 32'd0);
    check("post_reset_lost", 32'(sqw_lost), 32'd0);
    check("post_reset_glitch", 32'(glitch_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
